mips32_prog_loader: RTL and testbench

- Boot-time program loader directly upstream of the pipe_MIPS32 core.
- Accepts a byte stream carrying a length header, instruction words and a checksum, and writes each word into the core's shared instruction/data memory.
- Holds the core out of execution until the image is complete and its checksum verifies.
- Replaces the preloading of Mem[] and the clearing of PC/HALTED that the bench does by hand.

---
 rtl/mips32_pkg.sv | 22 ++
 rtl/mips32_byte_packer.sv | 41 ++++
 rtl/mips32_prog_loader.sv | 148 ++++++++++++++
 tb/tb_mips32_prog_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 program loader slice.
//   state_t : loader FSM state encoding (also exported on the debug port)
//   WORD_W  : instruction/data word width
//   BYTE_W  : input stream byte width
//   HLT_OP  : opcode of the HLT instruction that terminates loaded programs
package mips32_pkg;

  localparam int          WORD_W = 32;
  localparam int          BYTE_W = 8;
  localparam logic [5:0]  HLT_OP = 6'h3f;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

endpackage

// File: rtl/mips32_byte_packer.sv
// Big-endian 4-byte word assembler.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : restart assembly at byte 0 (drops any partial word)
//   in_valid    : a byte is consumed this cycle
//   in_data     : the byte; the first byte of a word is its MSB
//   word        : assembled word, meaningful while word_valid is high
//   word_valid  : in_valid on the 4th byte of a word
// The word is presented combinationally on the cycle its last byte is
// consumed, so the parent can register it on the same edge.
module mips32_byte_packer
  import mips32_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [23:0] shreg;
  logic [1:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (in_valid) begin
      shreg <= {shreg[15:0], in_data};
      cnt   <= cnt + 2'd1;  // wraps 3 -> 0 at each word boundary
    end
  end

  assign word       = {shreg, in_data};
  assign word_valid = in_valid && (cnt == 2'd3);

endmodule

// File: rtl/mips32_prog_loader.sv
// Boot-time program loader in front of the pipe_MIPS32 core.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : pulse; begins a load from IDLE/DONE/ERR
//   s_valid/s_ready/s_data : byte stream {N[15:0], N words, XOR checksum},
//                         all big-endian
//   mem_we/mem_addr/mem_wdata : one-cycle word write into core memory
//   cpu_run             : releases the core from reset once the image verifies
//   done / err          : load succeeded / failed (levels)
//   dbg_state           : current FSM state
//
// Stream handshake: a byte transfers on a rising edge where s_valid and
// s_ready are both high. s_ready depends only on the FSM state, never on
// s_valid; the sender may raise or drop s_valid at any cycle and the
// loader simply holds its state while s_valid is low.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              err,
  output state_t            dbg_state
);

  localparam int          DEPTH = 2 ** ADDR_W;
  // Number of words that fit between BASE_ADDR and the top of memory.
  localparam logic [16:0] ROOM  = 17'(DEPTH - BASE_ADDR);

  state_t              state, state_nxt;
  logic [7:0]          n_hi;
  logic [15:0]         n_words;
  logic [ADDR_W-1:0]   word_idx;
  logic [WORD_W-1:0]   acc;

  logic                accept;
  logic                start_ok;
  logic [15:0]         hdr_n;
  logic                last_word;
  logic                pk_valid;
  logic [WORD_W-1:0]   pk_word;
  logic                pk_word_valid;

  assign accept    = s_valid && s_ready;
  assign start_ok  = start && (state == ST_IDLE || state == ST_DONE ||
                               state == ST_ERR);
  assign hdr_n     = {n_hi, s_data};
  assign last_word = (32'(word_idx) + 32'd1) == 32'(n_words);
  assign pk_valid  = accept && (state == ST_DATA || state == ST_CSUM);
  assign dbg_state = state;

  mips32_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .in_valid   (pk_valid),
    .in_data    (s_data),
    .word       (pk_word),
    .word_valid (pk_word_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_nxt = ST_HDR0;
      end
      ST_HDR0: begin
        s_ready = 1'b1;
        if (accept) state_nxt = ST_HDR1;
      end
      ST_HDR1: begin
        s_ready = 1'b1;
        if (accept) begin
          if ({1'b0, hdr_n} > ROOM) state_nxt = ST_ERR;
          else if (hdr_n == 16'd0)  state_nxt = ST_CSUM;
          else                      state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        s_ready = 1'b1;
        // Leave on the same edge the last word's write strobe is raised.
        if (pk_word_valid && last_word) state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        s_ready = 1'b1;
        // acc already holds every data word: the last one was folded in
        // at least four accepted bytes earlier.
        if (pk_word_valid) state_nxt = (pk_word == acc) ? ST_DONE : ST_ERR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_hi      <= '0;
      n_words   <= '0;
      word_idx  <= '0;
      acc       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        n_hi     <= '0;
        n_words  <= '0;
        word_idx <= '0;
        acc      <= '0;
      end
      if (state == ST_HDR0 && accept) n_hi    <= s_data;
      if (state == ST_HDR1 && accept) n_words <= hdr_n;
      if (state == ST_DATA && pk_word_valid) begin
        mem_we    <= 1'b1;
        mem_addr  <= ADDR_W'(BASE_ADDR) + word_idx;
        mem_wdata <= pk_word;
        acc       <= acc ^ pk_word;
        word_idx  <= word_idx + 1'b1;
      end
      // Status levels follow the state being entered, so they change on
      // the same edge as the state register.
      done    <= (state_nxt == ST_DONE);
      cpu_run <= (state_nxt == ST_DONE);
      err     <= (state_nxt == ST_ERR);
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
module tb_mips32_prog_loader;
  import mips32_pkg::*;

  localparam int ADDR_W = 10;
  localparam int W      = ADDR_W + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              start;
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_run;
  logic              done;
  logic              err;
  state_t            dbg_state;

  mips32_prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_run   (cpu_run),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [31:0]  img [0:15];
  logic [31:0]  prog9 [0:8] = '{32'h2801000a, 32'h28020014, 32'h28030019,
                                32'h0ce77800, 32'h0ce77800, 32'h00222000,
                                32'h0ce77800, 32'h00832800, 32'hfc000000};

  // Observe writes and byte transfers mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (mem_we) got_q.push_back({mem_addr, mem_wdata});
    if (s_valid && s_ready) acc_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb;
    exp_q.delete();
    got_q.delete();
    acc_cnt = 0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps) begin
      for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom_range(0, 255));
        tick();
      end
    end
    s_valid = 1'b1;
    s_data  = b;
    guard   = 0;
    while (!s_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: s_ready=%0b required 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], gaps);
  endtask

  // Sends header, img[0..n-1] and the given checksum; queues expected writes.
  task automatic load_image(input int n, input logic [31:0] csum, input bit gaps);
    logic [15:0] nn;
    nn = 16'(n);
    send_byte(nn[15:8], gaps);
    send_byte(nn[7:0], gaps);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({ADDR_W'(i), img[i]});
      send_word(img[i], gaps);
    end
    send_word(csum, gaps);
  endtask

  function automatic logic [31:0] xor_img(input int n);
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < n; i++) x ^= img[i];
    return x;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
    #12;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if ({cpu_run, done, err} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {cpu_run, done, err}); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_program(input bit gaps);
    for (int i = 0; i < 9; i++) img[i] = prog9[i];
    clear_sb();
    pulse_start();
    checks++; if ({cpu_run, done} !== 2'b00) begin errors++; $display("FAIL prog_start_drop: got %b want 00", {cpu_run, done}); end
    load_image(9, xor_img(9), gaps);
    tick();
    checks++; if (got_q.size() !== 9) begin errors++; $display("FAIL prog_write_count: got %0d want 9", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [W-1:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL prog_write: got %h want %h", g, e); end
    end
    checks++; if ({done, cpu_run, err, s_ready} !== 4'b1100) begin errors++; $display("FAIL prog_status: got %b want 1100", {done, cpu_run, err, s_ready}); end
    checks++; if (acc_cnt !== 42) begin errors++; $display("FAIL prog_bytes: got %0d want 42", acc_cnt); end
    checks++; if (img[8][31:26] !== HLT_OP) begin errors++; $display("FAIL prog_hlt_last: got %h want %h", img[8][31:26], HLT_OP); end
  endtask

  task automatic test_bad_csum;
    img[0] = 32'hfc000000;
    clear_sb();
    pulse_start();
    load_image(1, 32'h00000000, 1'b0);
    tick();
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL badcs_write_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== {ADDR_W'(0), 32'hfc000000}) begin errors++; $display("FAIL badcs_write: got %h want %h", got_q[0], {ADDR_W'(0), 32'hfc000000}); end
    end
    checks++; if ({err, done, cpu_run} !== 3'b100) begin errors++; $display("FAIL badcs_status: got %b want 100", {err, done, cpu_run}); end
    repeat (3) tick();
    checks++; if (dbg_state !== ST_ERR) begin errors++; $display("FAIL badcs_hold: got %0d want %0d", dbg_state, ST_ERR); end
  endtask

  task automatic test_empty;
    clear_sb();
    pulse_start();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL empty_err_clear: got %b want 0", err); end
    load_image(0, 32'h00000000, 1'b0);
    tick();
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL empty_writes: got %0d want 0", got_q.size()); end
    checks++; if (acc_cnt !== 6) begin errors++; $display("FAIL empty_bytes: got %0d want 6", acc_cnt); end
    checks++; if ({done, cpu_run, err} !== 3'b110) begin errors++; $display("FAIL empty_status: got %b want 110", {done, cpu_run, err}); end
  endtask

  task automatic test_overflow;
    clear_sb();
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    checks++; if ({err, s_ready, done, cpu_run} !== 4'b1000) begin errors++; $display("FAIL ovf_status: got %b want 1000", {err, s_ready, done, cpu_run}); end
    repeat (2) tick();
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL ovf_writes: got %0d want 0", got_q.size()); end
    // Recovery with a small valid image: 11111111 ^ 22222222 = 33333333.
    img[0] = 32'h11111111;
    img[1] = 32'h22222222;
    clear_sb();
    pulse_start();
    load_image(2, 32'h33333333, 1'b0);
    tick();
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL ovf_recover_count: got %0d want 2", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [W-1:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL ovf_recover_write: got %h want %h", g, e); end
    end
    checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL ovf_recover_status: got %b want 10", {done, err}); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 9; i++) img[i] = prog9[i];
    clear_sb();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h09, 1'b0);
    for (int i = 0; i < 5; i++) send_word(img[i], 1'b0);
    checks++; if ({mem_we, mem_addr} !== {1'b1, ADDR_W'(4)}) begin errors++; $display("FAIL mid_fifth_write: got %b/%0d want 1/4", mem_we, mem_addr); end
    rst_n = 1'b0;
    #2;
    checks++; if ({s_ready, mem_we, cpu_run, done, err} !== 5'b00000) begin errors++; $display("FAIL mid_reset_ctrl: got %b want 00000", {s_ready, mem_we, cpu_run, done, err}); end
    checks++; if ({mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL mid_reset_bus: got %h want 0", {mem_addr, mem_wdata}); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL mid_reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_program(1'b0);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_program(1'b0);
    test_program(1'b1);
    test_bad_csum();
    test_empty();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
